mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20: SRAM word-address width.
REQ-002 Parameter XLEN, default C::XLEN: request address width.
REQ-003 Parameter RSP_DEPTH, default 2: response FIFO entries per port; legal values are 1 and 2 only.
REQ-004 clk  in  1  sole clock; every flop samples on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 f_req_valid / f_req_ready / f_req_addr  in / out / in  1 / 1 / XLEN  fetch request channel; fetch requests are always reads.
REQ-007 f_rsp_valid / f_rsp_ready / f_rsp_data  out / in / out  1 / 1 / 32  fetch response channel.
REQ-008 d_req_valid / d_req_ready / d_req_we / d_req_addr / d_req_wdata  in / out / in / in / in  1 / 1 / 1 / XLEN / 32  data request channel; d_req_we=1 selects a write.
REQ-009 d_rsp_valid / d_rsp_ready / d_rsp_data  out / in / out  1 / 1 / 32  data response channel; a write returns an acknowledge with data 0.
REQ-010 sram_we / sram_addr / sram_wdata / sram_rdata  out / out / out / in  1 / ADDR_WIDTH / 32 / 32  SRAM port: single port, 1-cycle read latency.

Function
REQ-011 The block SHALL issue at most one SRAM access per cycle.
- An access is a grant; a grant occurs when req_valid && req_ready are both 1 on a port in a cycle.
- f_req_ready and d_req_ready SHALL be combinational functions of the current state and the current valids, and SHALL never both be 1.
REQ-012 A port SHALL be eligible when occ < RSP_DEPTH, or when occ == RSP_DEPTH and rsp_valid && rsp_ready are both 1 in the same cycle.
- occ = in-flight read for that port (0/1) + that port's FIFO count.
REQ-013 Arbitration: round-robin between eligible valid ports.
- Priority goes to the port not granted most recently.
- After reset, fetch has priority.
- A lone eligible requester SHALL be granted every cycle.
REQ-014 SRAM drive on a grant: sram_addr = req_addr[ADDR_WIDTH+1:2], sram_we = granted write, sram_wdata = d_req_wdata.
- Address bits [1:0] and the bits above ADDR_WIDTH+1 are ignored; addresses alias.
REQ-015 With no grant: sram_we=0, sram_addr and sram_wdata hold their last values, and no response is generated.
REQ-016 Read grant in cycle N: tag (port) registered; sram_rdata is pushed into that port's FIFO at the edge ending cycle N+1; rsp_valid=1 from cycle N+2.
- Minimum latency is 2 cycles.
REQ-017 Write grant in cycle N: data 0 is pushed into the data FIFO at the edge ending N+1, following the same timing as a read.
REQ-018 Responses per port SHALL be returned in grant order.
- The FIFO SHALL never overflow; REQ-012 guarantees this.
- rsp_data SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-019 Simultaneous push and pop on a FIFO in one cycle: count is unchanged and the data order is preserved.
- This covers the full FIFO at RSP_DEPTH and the case count==1.
REQ-020 With both ports continuously valid and ready: the SRAM SHALL be busy every cycle, with grants alternating F,D,F,D.
REQ-021 A port whose rsp_ready is held 0 SHALL stall only itself; the other port keeps full throughput.
REQ-022 A port SHALL hold its request stable until it is granted.
- The block does not check this.

Reset
REQ-023 While rst=1, asynchronously:
- FIFOs emptied; f_rsp_valid=0, d_rsp_valid=0.
- In-flight tag cleared; a read in flight at reset is dropped and never returned.
- sram_we=0, sram_addr=0, sram_wdata=0.
- Round-robin priority set to fetch.
REQ-024 While rst=1, f_req_ready=0 and d_req_ready=0.
REQ-025 The first grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-026 Single fetch: f_req_addr=0x104, SRAM word 0x41 holds 0xDEADBEEF. Required: sram_addr=0x41 in the grant cycle, f_rsp_valid=1 with f_rsp_data=0xDEADBEEF exactly 2 cycles later, sram_we=0 throughout.
REQ-027 Write then read: d write 0x20 := 0x12345678, then d read 0x20. Required: first response data=0, second response=0x12345678, both returned in order on the d channel.
REQ-028 Contention: both valid for 8 cycles, both rsp_ready=1. Required: grants F,D,F,D,F,D,F,D and 4 responses per port.
REQ-029 Backpressure: f_rsp_ready=0, f_req_valid=1 held for 6 cycles. Required: exactly RSP_DEPTH fetch grants, then f_req_ready=0 until the first pop; d traffic is unaffected.
REQ-030 Reset mid-flight: rst pulsed in the cycle after a fetch grant. Required: f_rsp_valid stays 0, all outputs hold reset values, and a new fetch completes normally after reset.
REQ-031 Full-FIFO pop+grant: occ==RSP_DEPTH with rsp_ready=1 and req_valid=1. Required: grant in the same cycle and count unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port SRAM (1-cycle read latency) between an instruction
// fetch port and a data load/store port. At most one access is granted per
// cycle. Arbitration is round-robin, and fetch wins the first tie after reset.
// Each port has a small response FIFO. A port is only granted when its
// response is guaranteed a slot. Responses come back in grant order, with a
// minimum latency of 2 cycles. Writes return an acknowledge carrying data 0.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   f_req_*  (valid/ready/addr)  fetch read requests
//   f_rsp_*  (valid/ready/data)  fetch responses
//   d_req_*  (valid/ready/we/addr/wdata)  data read/write requests
//   d_rsp_*  (valid/ready/data)  data responses (write ack data = 0)
//   sram_*   (we/addr/wdata/rdata)        SRAM port, word addressed
// ---------------------------------------------------------------------------

package C;
    localparam int XLEN = 32;
endpackage

module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int XLEN       = C::XLEN,
    parameter int RSP_DEPTH  = 2        // 1 or 2 only
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  f_req_valid,
    output logic                  f_req_ready,
    input  logic [XLEN-1:0]       f_req_addr,
    output logic                  f_rsp_valid,
    input  logic                  f_rsp_ready,
    output logic [31:0]           f_rsp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [XLEN-1:0]       d_req_addr,
    input  logic [31:0]           d_req_wdata,
    output logic                  d_rsp_valid,
    input  logic                  d_rsp_ready,
    output logic [31:0]           d_rsp_data,

    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    // Port index 0 = fetch, 1 = data throughout.
    localparam logic [1:0] DEPTH_W = 2'(RSP_DEPTH);

    // In-flight access: granted last cycle, its SRAM data is valid this cycle.
    logic tag_vld_q, tag_vld_d;
    logic tag_port_q, tag_port_d;
    logic tag_we_q, tag_we_d;

    // 1: data port wins the next tie; 0: fetch wins.
    logic prio_d_q, prio_d_d;

    // SRAM address and write data hold their last value between grants.
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]           sram_wdata_q, sram_wdata_d;

    // Response FIFOs: [port][slot]. Slot 1 is unused when RSP_DEPTH == 1.
    logic [1:0][1:0][31:0] fifo_q, fifo_d;
    logic [1:0][1:0]       cnt_q, cnt_d;
    logic [1:0]            rd_q, rd_d;

    logic [1:0]       rsp_valid, rsp_ready, push, pop, elig, wr_idx;
    logic [1:0][1:0]  occ;
    logic [31:0]      push_data;
    logic             f_can, d_can, grant_f, grant_d, grant;

    // Only word-address bits reach the SRAM; the rest alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_req_addr, d_req_addr};

    // Occupancy and eligibility per port
    always_comb begin
        rsp_ready = {d_rsp_ready, f_rsp_ready};
        rsp_valid = '0;
        push      = '0;
        pop       = '0;
        occ       = '0;
        elig      = '0;
        for (int p = 0; p < 2; p++) begin
            rsp_valid[p] = (cnt_q[p] != 2'd0);
            pop[p]       = rsp_valid[p] && rsp_ready[p];
            // The in-flight access for this port lands in its FIFO at the
            // end of this cycle, so it counts toward occupancy now.
            push[p]      = tag_vld_q && (tag_port_q == 1'(p));
            occ[p]       = cnt_q[p] + {1'b0, push[p]};
            // A full port may still be granted when it pops this cycle:
            // the slot freed now is refilled two edges later at the earliest.
            elig[p]      = (occ[p] < DEPTH_W) || ((occ[p] == DEPTH_W) && pop[p]);
        end
    end

    // Round-robin grant
    always_comb begin
        f_can   = !rst && f_req_valid && elig[0];
        d_can   = !rst && d_req_valid && elig[1];
        grant_f = f_can && (!d_can || !prio_d_q);
        grant_d = d_can && !grant_f;
        grant   = grant_f || grant_d;

        prio_d_d = prio_d_q;
        if (grant_f)      prio_d_d = 1'b1;
        else if (grant_d) prio_d_d = 1'b0;

        tag_vld_d  = grant;
        tag_port_d = grant_d;
        tag_we_d   = grant_d && d_req_we;
    end

    assign f_req_ready = grant_f;
    assign d_req_ready = grant_d;

    // SRAM drive
    always_comb begin
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if (grant_d) begin
            sram_addr_d  = d_req_addr[ADDR_WIDTH+1:2];
            sram_wdata_d = d_req_wdata;
        end else if (grant_f) begin
            sram_addr_d  = f_req_addr[ADDR_WIDTH+1:2];
            sram_wdata_d = d_req_wdata;
        end
    end

    assign sram_we    = grant_d && d_req_we;
    assign sram_addr  = sram_addr_d;
    assign sram_wdata = sram_wdata_d;

    // Response FIFOs
    always_comb begin
        fifo_d    = fifo_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_idx    = '0;
        push_data = tag_we_q ? 32'd0 : sram_rdata;
        for (int p = 0; p < 2; p++) begin
            // When full, the write slot is the one being popped, which keeps
            // order on a simultaneous push+pop.
            wr_idx[p] = (RSP_DEPTH == 1) ? 1'b0 : (rd_q[p] ^ cnt_q[p][0]);
            if (push[p]) fifo_d[p][wr_idx[p]] = push_data;
            if (pop[p])  rd_d[p] = (RSP_DEPTH == 1) ? 1'b0 : ~rd_q[p];
            if (push[p] && !pop[p])      cnt_d[p] = cnt_q[p] + 2'd1;
            else if (!push[p] && pop[p]) cnt_d[p] = cnt_q[p] - 2'd1;
        end
    end

    assign f_rsp_valid = rsp_valid[0];
    assign f_rsp_data  = fifo_q[0][rd_q[0]];
    assign d_rsp_valid = rsp_valid[1];
    assign d_rsp_data  = fifo_q[1][rd_q[1]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q    <= 1'b0;
            tag_port_q   <= 1'b0;
            tag_we_q     <= 1'b0;
            prio_d_q     <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            fifo_q       <= '0;
            cnt_q        <= '0;
            rd_q         <= '0;
        end else begin
            tag_vld_q    <= tag_vld_d;
            tag_port_q   <= tag_port_d;
            tag_we_q     <= tag_we_d;
            prio_d_q     <= prio_d_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            fifo_q       <= fifo_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter (default parameters, RSP_DEPTH = 2).
// A per-cycle table covers reset, single fetch, write-then-read, contention,
// backpressure and full-FIFO pop+grant. Hand sequences cover response order
// with stalls and reset in the middle of a transfer.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
    logic [31:0] f_req_addr, f_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic        sram_we;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: read-before-write, 1-cycle read latency.
    logic [31:0] smem [1024];
    always @(posedge clk) begin
        sram_rdata <= smem[sram_addr[9:0]];
        if (sram_we) smem[sram_addr[9:0]] = sram_wdata;
    end

    typedef struct {
        logic        rst, fv;
        logic [31:0] fa;
        logic        fr, dv, dwe;
        logic [31:0] da, dwd;
        logic        dr;
        logic        e_frdy, e_drdy, e_we;
        logic [19:0] e_addr;
        logic        e_fv;
        logic [31:0] e_fd;
        logic        e_dv;
        logic [31:0] e_dd;
    } vec_t;

    localparam logic [31:0] FA = 32'h104, DA = 32'h20;
    localparam logic [19:0] WF = 20'h41,  WD = 20'h8;
    localparam logic [31:0] DB = 32'hDEADBEEF, DW = 32'h12345678;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt[$];

    function automatic vec_t mk(logic r, logic fv, logic [31:0] fa, logic fr,
                                logic dv, logic dwe, logic [31:0] da, logic [31:0] dwd, logic dr,
                                logic e_frdy, logic e_drdy, logic e_we, logic [19:0] e_addr,
                                logic e_fv, logic [31:0] e_fd, logic e_dv, logic [31:0] e_dd);
        vec_t v;
        v.rst = r; v.fv = fv; v.fa = fa; v.fr = fr; v.dv = dv; v.dwe = dwe;
        v.da = da; v.dwd = dwd; v.dr = dr;
        v.e_frdy = e_frdy; v.e_drdy = e_drdy; v.e_we = e_we; v.e_addr = e_addr;
        v.e_fv = e_fv; v.e_fd = e_fd; v.e_dv = e_dv; v.e_dd = e_dd;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; f_req_valid = v.fv; f_req_addr = v.fa; f_rsp_ready = v.fr;
        d_req_valid = v.dv; d_req_we = v.dwe; d_req_addr = v.da; d_req_wdata = v.dwd;
        d_rsp_ready = v.dr;
    endtask

    task automatic check_vec(int i, vec_t v);
        n_vec++;
        chk($sformatf("v%0d.f_req_ready", i), 32'(f_req_ready), 32'(v.e_frdy));
        chk($sformatf("v%0d.d_req_ready", i), 32'(d_req_ready), 32'(v.e_drdy));
        chk($sformatf("v%0d.sram_we", i),     32'(sram_we),     32'(v.e_we));
        chk($sformatf("v%0d.sram_addr", i),   32'(sram_addr),   32'(v.e_addr));
        chk($sformatf("v%0d.f_rsp_valid", i), 32'(f_rsp_valid), 32'(v.e_fv));
        chk($sformatf("v%0d.d_rsp_valid", i), 32'(d_rsp_valid), 32'(v.e_dv));
        if (v.e_fv) chk($sformatf("v%0d.f_rsp_data", i), f_rsp_data, v.e_fd);
        if (v.e_dv) chk($sformatf("v%0d.d_rsp_data", i), d_rsp_data, v.e_dd);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_d, held;
        logic        stalled;
        int          issued, got;

        for (int i = 0; i < 1024; i++) smem[i] = 32'h0;
        smem[10'h041] = DB;
        for (int i = 0; i < 4; i++) smem[10'h100 + i] = 32'hA000_0000 | 32'(i);

        rst = 1'b1; f_req_valid = 0; f_req_addr = 0; f_rsp_ready = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_rsp_ready = 0;

        //        rst fv fa fr dv we da dwd dr | frdy drdy we addr fv fd dv dd
        // reset: requests held off
        vt.push_back(mk(1,1,FA,1, 1,0,DA,0,1,  0,0,0,20'h0, 0,0,  0,0));
        // single fetch of 0x104 -> word 0x41
        vt.push_back(mk(0,1,FA,1, 0,0,0,0,1,   1,0,0,WF, 0,0,  0,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WF, 0,0,  0,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WF, 1,DB, 0,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WF, 0,0,  0,0));
        // write 0x20 := 0x12345678, then read 0x20
        vt.push_back(mk(0,0,0,1,  1,1,DA,DW,1, 0,1,1,WD, 0,0,  0,0));
        vt.push_back(mk(0,0,0,1,  1,0,DA,0,1,  0,1,0,WD, 0,0,  0,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WD, 0,0,  1,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WD, 0,0,  1,DW));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WD, 0,0,  0,0));
        // contention: 8 cycles, F,D,F,D,...
        for (int k = 0; k < 4; k++) begin
            vt.push_back(mk(0,1,FA,1, 1,0,DA,0,1, 1,0,0,WF, (k > 0),DB, 0,0));
            vt.push_back(mk(0,1,FA,1, 1,0,DA,0,1, 0,1,0,WD, 0,0, (k > 0),DW));
        end
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WD, 1,DB, 0,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WD, 0,0,  1,DW));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WD, 0,0,  0,0));
        // backpressure on fetch for 6 cycles; data keeps flowing
        vt.push_back(mk(0,1,FA,0, 1,0,DA,0,1,  1,0,0,WF, 0,0,  0,0));
        vt.push_back(mk(0,1,FA,0, 1,0,DA,0,1,  0,1,0,WD, 0,0,  0,0));
        vt.push_back(mk(0,1,FA,0, 1,0,DA,0,1,  1,0,0,WF, 1,DB, 0,0));
        vt.push_back(mk(0,1,FA,0, 1,0,DA,0,1,  0,1,0,WD, 1,DB, 1,DW));
        vt.push_back(mk(0,1,FA,0, 1,0,DA,0,1,  0,1,0,WD, 1,DB, 0,0));
        vt.push_back(mk(0,1,FA,0, 1,0,DA,0,1,  0,1,0,WD, 1,DB, 1,DW));
        // full FIFO: pop and grant in the same cycle
        vt.push_back(mk(0,1,FA,1, 1,0,DA,0,1,  1,0,0,WF, 1,DB, 1,DW));
        // occupancy still at depth, no pop -> no grant
        vt.push_back(mk(0,1,FA,0, 0,0,0,0,1,   0,0,0,WF, 1,DB, 1,DW));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WF, 1,DB, 0,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WF, 1,DB, 0,0));
        vt.push_back(mk(0,0,0,1,  0,0,0,0,1,   0,0,0,WF, 0,0,  0,0));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            check_vec(i, vt[i]);
        end

        // Response order with stalls: 4 fetches to distinct words
        issued = 0; got = 0; stalled = 1'b0; held = 0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            f_req_valid = (issued < 4);
            f_req_addr  = 32'h400 + 32'(issued * 4);
            f_rsp_ready = ((cyc % 3) != 1);
            d_req_valid = 1'b0;
            #1;
            if (stalled) begin
                n_vec++;
                chk("hold.f_rsp_valid", 32'(f_rsp_valid), 32'd1);
                chk("hold.f_rsp_data", f_rsp_data, held);
            end
            if (f_req_valid && f_req_ready) begin
                q.push_back(32'hA000_0000 | 32'(issued));
                issued++;
            end
            if (f_rsp_valid && f_rsp_ready) begin
                n_vec++;
                exp_d = (q.size() > 0) ? q.pop_front() : 32'hXXXX_XXXX;
                chk($sformatf("order.rsp%0d", got), f_rsp_data, exp_d);
                got++;
            end
            stalled = f_rsp_valid && !f_rsp_ready;
            held    = f_rsp_data;
        end
        n_vec++;
        chk("order.count", 32'(got), 32'd4);

        // Reset in the cycle after a fetch grant
        @(negedge clk);
        f_req_valid = 1; f_req_addr = FA; f_rsp_ready = 1;
        #1;
        n_vec++;
        chk("rstflt.grant", 32'(f_req_ready), 32'd1);
        @(negedge clk);
        rst = 1; f_req_valid = 1; d_req_valid = 1; d_req_we = 1;
        d_req_addr = 32'h40; d_req_wdata = 32'h5555_AAAA;
        #1;
        n_vec++;
        chk("rst.f_req_ready", 32'(f_req_ready), 32'd0);
        chk("rst.d_req_ready", 32'(d_req_ready), 32'd0);
        chk("rst.sram_we", 32'(sram_we), 32'd0);
        chk("rst.sram_addr", 32'(sram_addr), 32'd0);
        chk("rst.sram_wdata", sram_wdata, 32'd0);
        chk("rst.f_rsp_valid", 32'(f_rsp_valid), 32'd0);
        chk("rst.d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 0; f_req_valid = 0; d_req_valid = 0; d_req_we = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            chk($sformatf("rst.dropped%0d", k), 32'(f_rsp_valid), 32'd0);
            @(negedge clk);
        end
        f_req_valid = 1; f_req_addr = 32'h400;
        #1;
        n_vec++;
        chk("post.grant", 32'(f_req_ready), 32'd1);
        chk("post.sram_addr", 32'(sram_addr), 32'h100);
        @(negedge clk);
        f_req_valid = 0;
        #1;
        n_vec++;
        chk("post.early", 32'(f_rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        n_vec++;
        chk("post.f_rsp_valid", 32'(f_rsp_valid), 32'd1);
        chk("post.f_rsp_data", f_rsp_data, 32'hA000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
